memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage.sv | 163 ++++++++++++++++
 tb/tb_memory_stage.sv | 519 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// Memory stage: M and W pipeline registers, data-memory access FSM,
// stall generation, misalignment and watchdog error reporting.
module memory_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [1:0]  ex_mem_op,
    input  logic [1:0]  ex_wb_sel,
    input  logic [4:0]  ex_rd,
    input  logic        result_P,
    input  logic [31:0] result_I,
    input  logic [31:0] result_F,
    input  logic [31:0] Wdata,
    input  logic        flush,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mm_stall,
    output logic        pval_mm,
    output logic [31:0] rval_mm,
    output logic [31:0] fval_mm,
    output logic        wb_valid,
    output logic [1:0]  wb_sel,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_pdata,
    output logic        mem_err
);
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] SEL_F    = 2'b11;
    localparam logic [7:0] WD_LAST  = 8'd254;

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [1:0]  op;
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic        p;
        logic [31:0] ri;
        logic [31:0] rf;
        logic [31:0] wd;
    } m_t;

    state_t      r_state;
    logic [7:0]  r_wdog;
    m_t          r_m;
    logic        r_err;
    logic        r_wb_valid;
    logic [1:0]  r_wb_sel;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic        r_wb_pdata;

    logic        w_ex_mem;
    logic        w_ex_go;
    logic        w_access;
    logic        w_wd_expire;
    logic        w_stall;
    logic        w_m_mem;
    logic        w_m_mis;
    logic        w_m_retire;
    logic [31:0] w_m_data;

    assign w_ex_mem = (ex_mem_op == OP_LOAD) || (ex_mem_op == OP_STORE);
    assign w_ex_go  = ex_valid & ~flush & w_ex_mem
                    & (result_I[1:0] == 2'b00);

    // The 255th unacknowledged ACCESS cycle abandons the request.
    assign w_access    = (r_state == ST_ACCESS);
    assign w_wd_expire = w_access & ~dmem_ack & (r_wdog == WD_LAST);
    assign w_stall     = w_access & ~dmem_ack & ~w_wd_expire;

    assign w_m_mem = (r_m.op == OP_LOAD) || (r_m.op == OP_STORE);
    assign w_m_mis = r_m.valid & w_m_mem & (r_m.ri[1:0] != 2'b00);

    assign w_m_retire = r_m.valid & ~w_m_mis & ~w_wd_expire
                      & (r_m.op != OP_STORE);

    assign w_m_data = (r_m.op == OP_LOAD) ? dmem_rdata :
                      (r_m.sel == SEL_F)  ? r_m.rf     :
                                            r_m.ri;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_wdog  <= '0;
        end else if (!w_stall) begin
            r_state <= w_ex_go ? ST_ACCESS : ST_IDLE;
            r_wdog  <= '0;
        end else begin
            r_wdog  <= r_wdog + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m <= '0;
        end else if (!w_stall) begin
            r_m <= '{
                valid: ex_valid & ~flush,
                op:    ex_mem_op,
                sel:   ex_wb_sel,
                rd:    ex_rd,
                p:     result_P,
                ri:    result_I,
                rf:    result_F,
                wd:    Wdata
            };
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_valid <= 1'b0;
            r_wb_sel   <= '0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_wb_pdata <= 1'b0;
        end else if (w_stall) begin
            r_wb_valid <= 1'b0;
        end else begin
            r_wb_valid <= w_m_retire;
            r_wb_sel   <= r_m.sel;
            r_wb_rd    <= r_m.rd;
            r_wb_data  <= w_m_data;
            r_wb_pdata <= r_m.p;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_wd_expire || (w_m_mis && !w_stall)) begin
            r_err <= 1'b1;
        end
    end

    assign dmem_req   = w_access;
    assign dmem_we    = w_access & (r_m.op == OP_STORE);
    assign dmem_addr  = w_access ? r_m.ri : '0;
    assign dmem_wdata = w_access ? r_m.wd : '0;
    assign mm_stall   = w_stall;

    assign pval_mm = r_m.p;
    assign rval_mm = r_m.ri;
    assign fval_mm = r_m.rf;

    assign wb_valid = r_wb_valid;
    assign wb_sel   = r_wb_sel;
    assign wb_rd    = r_wb_rd;
    assign wb_data  = r_wb_data;
    assign wb_pdata = r_wb_pdata;
    assign mem_err  = r_err;
endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus a
// randomized run scored against a transaction-level reference model.
module tb_memory_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid;
    logic [1:0]  ex_mem_op;
    logic [1:0]  ex_wb_sel;
    logic [4:0]  ex_rd;
    logic        result_P;
    logic [31:0] result_I;
    logic [31:0] result_F;
    logic [31:0] Wdata;
    logic        flush;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        mm_stall;
    logic        pval_mm;
    logic [31:0] rval_mm;
    logic [31:0] fval_mm;
    logic        wb_valid;
    logic [1:0]  wb_sel;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_pdata;
    logic        mem_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_mem_op(ex_mem_op),
        .ex_wb_sel(ex_wb_sel), .ex_rd(ex_rd),
        .result_P(result_P), .result_I(result_I),
        .result_F(result_F), .Wdata(Wdata), .flush(flush),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .mm_stall(mm_stall), .pval_mm(pval_mm),
        .rval_mm(rval_mm), .fval_mm(fval_mm),
        .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_pdata(wb_pdata), .mem_err(mem_err)
    );

    typedef struct {
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic        p;
        logic [31:0] data;
        bit          is_load;
        bit          chk_data;
    } ret_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wd;
    } req_t;

    ret_t        exp_ret[$];
    req_t        exp_req[$];
    logic [31:0] ld_data[$];

    task automatic set_ex(input logic v, input logic [1:0] op,
                          input logic [1:0] sel, input logic [4:0] rd,
                          input logic p, input logic [31:0] ri,
                          input logic [31:0] rf, input logic [31:0] wd,
                          input logic fl);
        ex_valid  = v;
        ex_mem_op = op;
        ex_wb_sel = sel;
        ex_rd     = rd;
        result_P  = p;
        result_I  = ri;
        result_F  = rf;
        Wdata     = wd;
        flush     = fl;
    endtask

    task automatic idle_ex();
        set_ex(1'b0, 2'b00, 2'b00, 5'd0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        dmem_ack = 1'b0;
        idle_ex();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [113:0] v;
        rst = 1'b0;
        idle_ex();
        #1;
        v = {dmem_req, dmem_we, mm_stall, dmem_addr, dmem_wdata,
             wb_valid, wb_sel, wb_rd, wb_data, wb_pdata, mem_err};
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", v);
        end
        do_reset();
    endtask

    task automatic test_alu();
        int stalls = 0;
        do_reset();
        set_ex(1'b1, 2'b00, 2'b01, 5'd5, 1'b1, 32'h1234, 32'h0, 32'h0,
               1'b0);
        @(negedge clk);
        stalls += int'(mm_stall);
        idle_ex();
        checks++;
        if (rval_mm !== 32'h1234 || pval_mm !== 1'b1) begin
            errors++;
            $display("FAIL alu_fwd got %h/%b want 1234/1", rval_mm, pval_mm);
        end
        @(negedge clk);
        stalls += int'(mm_stall);
        checks++;
        if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_sel !== 2'b01) begin
            errors++;
            $display("FAIL alu_wb_ctl got %b/%0d/%b want 1/5/01",
                     wb_valid, wb_rd, wb_sel);
        end
        checks++;
        if (wb_data !== 32'h1234 || wb_pdata !== 1'b1) begin
            errors++;
            $display("FAIL alu_wb_data got %h/%b want 1234/1",
                     wb_data, wb_pdata);
        end
        checks++;
        if (stalls != 0) begin
            errors++;
            $display("FAIL alu_stall got %0d want 0", stalls);
        end
    endtask

    task automatic test_load();
        int reqs = 0;
        int stalls = 0;
        do_reset();
        set_ex(1'b1, 2'b01, 2'b01, 5'd7, 1'b0, 32'h100, 32'h0, 32'h0,
               1'b0);
        @(negedge clk);
        idle_ex();
        for (int k = 0; k < 3; k++) begin
            dmem_ack   = (k == 2);
            dmem_rdata = (k == 2) ? 32'hDEADBEEF : $urandom;
            #1;
            reqs   += int'(dmem_req);
            stalls += int'(mm_stall);
            if (k == 0) begin
                checks++;
                if (dmem_addr !== 32'h100 || dmem_we !== 1'b0) begin
                    errors++;
                    $display("FAIL load_addr got %h/%b want 100/0",
                             dmem_addr, dmem_we);
                end
            end
            @(negedge clk);
        end
        dmem_ack = 1'b0;
        checks++;
        if (reqs != 3 || stalls != 2) begin
            errors++;
            $display("FAIL load_timing got req %0d stall %0d want 3 2",
                     reqs, stalls);
        end
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== 32'hDEADBEEF
            || wb_rd !== 5'd7 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL load_wb got %b/%h/%0d/%b want 1/deadbeef/7/0",
                     wb_valid, wb_data, wb_rd, dmem_req);
        end
    endtask

    task automatic test_store();
        do_reset();
        set_ex(1'b1, 2'b10, 2'b00, 5'd3, 1'b0, 32'h200, 32'h0,
               32'hA5A5A5A5, 1'b0);
        @(negedge clk);
        idle_ex();
        dmem_ack = 1'b1;
        #1;
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1
            || dmem_addr !== 32'h200 || dmem_wdata !== 32'hA5A5A5A5
            || mm_stall !== 1'b0) begin
            errors++;
            $display("FAIL store_req got %b%b %h %h stall %b",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata, mm_stall);
        end
        @(negedge clk);
        dmem_ack = 1'b0;
        checks++;
        if (wb_valid !== 1'b0 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL store_wb got %b/%b want 0/0", wb_valid, dmem_req);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1;
        logic [31:0] r2;
        r1 = $urandom;
        r2 = $urandom;
        do_reset();
        set_ex(1'b1, 2'b01, 2'b01, 5'd1, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        set_ex(1'b1, 2'b01, 2'b11, 5'd2, 1'b1, 32'h14, 32'h0, 32'h0, 1'b0);
        dmem_ack   = 1'b1;
        dmem_rdata = r1;
        #1;
        checks++;
        if (dmem_req !== 1'b1 || dmem_addr !== 32'h10) begin
            errors++;
            $display("FAIL b2b_first got %b %h want 1 10",
                     dmem_req, dmem_addr);
        end
        @(negedge clk);
        idle_ex();
        dmem_rdata = r2;
        #1;
        checks++;
        if (dmem_req !== 1'b1 || dmem_addr !== 32'h14
            || wb_valid !== 1'b1 || wb_data !== r1) begin
            errors++;
            $display("FAIL b2b_second got %b %h %b %h want 1 14 1 %h",
                     dmem_req, dmem_addr, wb_valid, wb_data, r1);
        end
        @(negedge clk);
        dmem_ack = 1'b0;
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== r2 || wb_rd !== 5'd2
            || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done got %b %h %0d %b want 1 %h 2 0",
                     wb_valid, wb_data, wb_rd, dmem_req, r2);
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        set_ex(1'b1, 2'b01, 2'b01, 5'd4, 1'b0, 32'h102, 32'h0, 32'h0,
               1'b0);
        @(negedge clk);
        set_ex(1'b1, 2'b00, 2'b01, 5'd9, 1'b0, 32'h99, 32'h0, 32'h0,
               1'b0);
        #1;
        checks++;
        if (dmem_req !== 1'b0 || mm_stall !== 1'b0) begin
            errors++;
            $display("FAIL mis_noreq got %b/%b want 0/0", dmem_req, mm_stall);
        end
        @(negedge clk);
        idle_ex();
        #1;
        checks++;
        if (mem_err !== 1'b1 || wb_valid !== 1'b0 || mm_stall !== 1'b0) begin
            errors++;
            $display("FAIL mis_err got %b/%b/%b want 1/0/0",
                     mem_err, wb_valid, mm_stall);
        end
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b1 || wb_rd !== 5'd9 || wb_data !== 32'h99
            || mem_err !== 1'b1) begin
            errors++;
            $display("FAIL mis_next got %b %0d %h %b want 1 9 99 1",
                     wb_valid, wb_rd, wb_data, mem_err);
        end
    endtask

    task automatic test_watchdog();
        int reqs = 0;
        int stalls = 0;
        do_reset();
        set_ex(1'b1, 2'b01, 2'b01, 5'd6, 1'b0, 32'h300, 32'h0, 32'h0,
               1'b0);
        @(negedge clk);
        idle_ex();
        dmem_ack = 1'b0;
        while (dmem_req === 1'b1 && reqs < 400) begin
            reqs   += 1;
            stalls += int'(mm_stall);
            @(negedge clk);
        end
        checks++;
        if (reqs != 255 || stalls != 254) begin
            errors++;
            $display("FAIL wdog_len got req %0d stall %0d want 255 254",
                     reqs, stalls);
        end
        checks++;
        if (mem_err !== 1'b1 || dmem_req !== 1'b0 || mm_stall !== 1'b0
            || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL wdog_end got %b%b%b%b want 1000",
                     mem_err, dmem_req, mm_stall, wb_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [113:0] v;
        bit seen = 0;
        do_reset();
        set_ex(1'b1, 2'b01, 2'b01, 5'd3, 1'b0, 32'h400, 32'h0, 32'h0,
               1'b0);
        @(negedge clk);
        set_ex(1'b1, 2'b00, 2'b01, 5'd17, 1'b1, 32'h777, 32'h0, 32'h0,
               1'b1);
        #1;
        checks++;
        if (mm_stall !== 1'b1) begin
            errors++;
            $display("FAIL rmid_stall got %b want 1", mm_stall);
        end
        #1;
        rst = 1'b0;
        #1;
        v = {dmem_req, dmem_we, mm_stall, dmem_addr, dmem_wdata,
             wb_valid, wb_sel, wb_rd, wb_data, wb_pdata, mem_err};
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL rmid_outputs got %h want 0", v);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            idle_ex();
            if (wb_valid === 1'b1 && wb_rd === 5'd17) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rmid_flush got retired want squashed");
        end
    endtask

    task automatic accept(input logic v, input logic [1:0] op,
                          input logic [1:0] sel, input logic [4:0] rd,
                          input logic p, input logic [31:0] ri,
                          input logic [31:0] rf, input logic [31:0] wd,
                          input logic fl, inout bit err);
        ret_t r;
        req_t q;
        bit   mem;
        if (!v || fl) return;
        mem = (op == 2'b01) || (op == 2'b10);
        r.sel = sel;
        r.rd  = rd;
        r.p   = p;
        if (mem && ri[1:0] != 2'b00) begin
            err = 1;
        end else if (mem) begin
            q.we   = (op == 2'b10);
            q.addr = ri;
            q.wd   = wd;
            exp_req.push_back(q);
            if (op == 2'b01) begin
                r.data     = '0;
                r.is_load  = 1;
                r.chk_data = 1;
                exp_ret.push_back(r);
            end
        end else begin
            r.data     = (sel == 2'b11) ? rf : ri;
            r.is_load  = 0;
            r.chk_data = (sel == 2'b01) || (sel == 2'b11);
            exp_ret.push_back(r);
        end
    endtask

    task automatic test_random();
        int          lat = -1;
        bit          have = 0;
        bit          exp_err = 0;
        int          retired = 0;
        logic        c_v, c_p, c_fl;
        logic [1:0]  c_op, c_sel;
        logic [4:0]  c_rd;
        logic [31:0] c_ri, c_rf, c_wd, rnd, want;
        ret_t        e;
        req_t        q;
        exp_ret.delete();
        exp_req.delete();
        ld_data.delete();
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            if (wb_valid === 1'b1) begin
                retired++;
                checks++;
                if (exp_ret.size() == 0) begin
                    errors++;
                    $display("FAIL rand_ret got rd %0d want nothing", wb_rd);
                end else begin
                    e = exp_ret.pop_front();
                    want = e.data;
                    if (e.is_load)
                        want = (ld_data.size() > 0) ? ld_data.pop_front()
                                                    : 32'hx;
                    if (wb_sel !== e.sel || wb_rd !== e.rd
                        || wb_pdata !== e.p
                        || (e.chk_data && wb_data !== want)) begin
                        errors++;
                        $display("FAIL rand_ret got %b %0d %b %h want %b %0d %b %h",
                                 wb_sel, wb_rd, wb_pdata, wb_data,
                                 e.sel, e.rd, e.p, want);
                    end
                end
            end
            if (dmem_req === 1'b1) begin
                if (lat < 0) lat = int'($urandom_range(0, 4));
                if (lat == 0) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = $urandom;
                    lat = -1;
                    checks++;
                    if (exp_req.size() == 0) begin
                        errors++;
                        $display("FAIL rand_req got %h want nothing",
                                 dmem_addr);
                    end else begin
                        q = exp_req.pop_front();
                        if (dmem_we !== q.we || dmem_addr !== q.addr
                            || (q.we && dmem_wdata !== q.wd)) begin
                            errors++;
                            $display("FAIL rand_req got %b %h %h want %b %h %h",
                                     dmem_we, dmem_addr, dmem_wdata,
                                     q.we, q.addr, q.wd);
                        end
                    end
                    if (dmem_we !== 1'b1) ld_data.push_back(dmem_rdata);
                end else begin
                    dmem_ack = 1'b0;
                    lat--;
                end
            end else begin
                dmem_ack   = 1'($urandom_range(0, 1));
                dmem_rdata = $urandom;
            end
            if (!have) begin
                if (cyc < 1400) begin
                    c_v   = ($urandom_range(0, 4) != 0);
                    c_op  = 2'($urandom_range(0, 3));
                    c_sel = 2'($urandom_range(0, 3));
                    c_rd  = 5'($urandom_range(0, 31));
                    c_p   = 1'($urandom_range(0, 1));
                    rnd   = $urandom;
                    c_ri  = {rnd[31:2], 2'b00};
                    if ($urandom_range(0, 7) == 0)
                        c_ri[1:0] = 2'($urandom_range(1, 3));
                    c_rf  = $urandom;
                    c_wd  = $urandom;
                    c_fl  = ($urandom_range(0, 7) == 0);
                end else begin
                    c_v = 0; c_op = 0; c_sel = 0; c_rd = 0; c_p = 0;
                    c_ri = 0; c_rf = 0; c_wd = 0; c_fl = 0;
                end
                have = 1;
            end
            set_ex(c_v, c_op, c_sel, c_rd, c_p, c_ri, c_rf, c_wd, c_fl);
            #1;
            if (mm_stall === 1'b0) begin
                accept(c_v, c_op, c_sel, c_rd, c_p, c_ri, c_rf, c_wd,
                       c_fl, exp_err);
                have = 0;
            end
        end
        dmem_ack = 1'b0;
        checks++;
        if (exp_ret.size() != 0 || exp_req.size() != 0
            || ld_data.size() != 0) begin
            errors++;
            $display("FAIL rand_drain got %0d/%0d/%0d left want 0/0/0",
                     exp_ret.size(), exp_req.size(), ld_data.size());
        end
        checks++;
        if (mem_err !== exp_err) begin
            errors++;
            $display("FAIL rand_err got %b want %b", mem_err, exp_err);
        end
        checks++;
        if (retired < 100) begin
            errors++;
            $display("FAIL rand_volume got %0d want >=100", retired);
        end
    endtask

    initial begin
        idle_ex();
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_back_to_back();
        test_misaligned();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
